// File: rtl/axi_wdata_sfifo.sv
// ----------------------------------------------------------------------------
// axi_wdata_sfifo
//   AXI write-data upsizing FIFO. Narrow W beats (S_WTH) are packed into wide
//   words (M_WTH). The start lane of a burst comes from the AW address offset.
//   Byte strobes and the burst-last marker travel with each wide word.
//   Read side is show-ahead.
//
// Ports
//   clk, rstn                   clock, asynchronous active-low reset
//   wen/wdata/wstrb/wlast       narrow beat in (accepted when !full)
//   awaddr_offset               start lane of a burst
//   saddr_init_flag             beat is the first of a burst (lane := offset)
//   full, almost_full           count == DEPTH, count >= DEPTH-1
//   ren                         pop head word (ignored when empty)
//   rdata/rstrb/rlast           head word, zero when empty
//   empty, almost_empty         count == 0, count <= 1
// ----------------------------------------------------------------------------
module axi_wdata_sfifo #(
   parameter int unsigned S_WTH = 32,
   parameter int unsigned M_WTH = 64,
   parameter int unsigned DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic                            wen,
   input  logic [S_WTH-1:0]                wdata,
   input  logic [S_WTH/8-1:0]              wstrb,
   input  logic                            wlast,
   input  logic [$clog2(M_WTH/S_WTH)-1:0]  awaddr_offset,
   input  logic                            saddr_init_flag,
   output logic                            full,
   output logic                            almost_full,
   input  logic                            ren,
   output logic [M_WTH-1:0]                rdata,
   output logic [M_WTH/8-1:0]              rstrb,
   output logic                            rlast,
   output logic                            empty,
   output logic                            almost_empty
);

   localparam int unsigned RATIO  = M_WTH / S_WTH;
   localparam int unsigned LANE_W = $clog2(RATIO);
   localparam int unsigned SB_W   = S_WTH / 8;
   localparam int unsigned MB_W   = M_WTH / 8;
   localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

   logic [LANE_W-1:0] lane_q, lane_d, cur_lane;
   logic [M_WTH-1:0]  pack_data_q, pack_data_d, word_data;
   logic [MB_W-1:0]   pack_strb_q, pack_strb_d, word_strb;
   logic [PTR_W-1:0]  waddr_q, waddr_d, raddr_q, raddr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              accept, commit, pop;

   logic [M_WTH-1:0]  mem_data_q [DEPTH];
   logic [MB_W-1:0]   mem_strb_q [DEPTH];
   logic              mem_last_q [DEPTH];

   // Occupancy flags straight from the registered count
   assign full         = (count_q == CNT_W'(DEPTH));
   assign almost_full  = (count_q >= CNT_W'(DEPTH - 1));
   assign empty        = (count_q == '0);
   assign almost_empty = (count_q <= CNT_W'(1));

   assign accept   = wen && !full;
   assign pop      = ren && !empty;
   assign cur_lane = saddr_init_flag ? awaddr_offset : lane_q;
   assign commit   = accept && ((cur_lane == LANE_W'(RATIO - 1)) || wlast);

   // Pack register merged with the current beat: the word that a commit stores
   always_comb begin
      word_data = pack_data_q;
      word_strb = pack_strb_q;
      word_data[cur_lane*S_WTH +: S_WTH] = wdata;
      word_strb[cur_lane*SB_W +: SB_W]   = wstrb;
   end

   // Next-state for lane, pack register, pointers and count
   always_comb begin
      lane_d      = lane_q;
      pack_data_d = pack_data_q;
      pack_strb_d = pack_strb_q;
      waddr_d     = waddr_q;
      raddr_d     = raddr_q;
      count_d     = count_q;

      if (accept) begin
         if (commit) begin
            lane_d      = '0;
            pack_data_d = '0;
            pack_strb_d = '0;
            waddr_d     = (waddr_q == PTR_W'(DEPTH - 1)) ? '0 : waddr_q + PTR_W'(1);
         end else begin
            lane_d      = cur_lane + LANE_W'(1);
            pack_data_d = word_data;
            pack_strb_d = word_strb;
         end
      end

      if (pop) begin
         raddr_d = (raddr_q == PTR_W'(DEPTH - 1)) ? '0 : raddr_q + PTR_W'(1);
      end

      case ({commit, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         lane_q      <= '0;
         pack_data_q <= '0;
         pack_strb_q <= '0;
         waddr_q     <= '0;
         raddr_q     <= '0;
         count_q     <= '0;
      end else begin
         lane_q      <= lane_d;
         pack_data_q <= pack_data_d;
         pack_strb_q <= pack_strb_d;
         waddr_q     <= waddr_d;
         raddr_q     <= raddr_d;
         count_q     <= count_d;
      end
   end

   // Storage array; contents are only visible through a valid count, so no reset
   always_ff @(posedge clk) begin
      if (commit) begin
         mem_data_q[waddr_q] <= word_data;
         mem_strb_q[waddr_q] <= word_strb;
         mem_last_q[waddr_q] <= wlast;
      end
   end

   // Show-ahead read, zeroed while empty
   assign rdata = empty ? '0   : mem_data_q[raddr_q];
   assign rstrb = empty ? '0   : mem_strb_q[raddr_q];
   assign rlast = empty ? 1'b0 : mem_last_q[raddr_q];

endmodule

// File: tb/tb_axi_wdata_sfifo.sv
// ----------------------------------------------------------------------------
// tb_axi_wdata_sfifo
//   Self-checking bench for axi_wdata_sfifo (S_WTH=32, M_WTH=64, DEPTH=4).
//   Directed scenarios use constant expectations; the random streams use a
//   burst-level reference model that places each beat at slot offset+i and
//   derives wide words from slot/RATIO and slot%RATIO.
// ----------------------------------------------------------------------------
module tb_axi_wdata_sfifo;

   localparam int unsigned S_WTH  = 32;
   localparam int unsigned M_WTH  = 64;
   localparam int unsigned DEPTH  = 4;
   localparam int unsigned RATIO  = M_WTH / S_WTH;
   localparam int unsigned LANE_W = 1;

   logic                 clk = 1'b0;
   logic                 rstn;
   logic                 wen;
   logic [S_WTH-1:0]     wdata;
   logic [S_WTH/8-1:0]   wstrb;
   logic                 wlast;
   logic [LANE_W-1:0]    awaddr_offset;
   logic                 saddr_init_flag;
   logic                 full, almost_full;
   logic                 ren;
   logic [M_WTH-1:0]     rdata;
   logic [M_WTH/8-1:0]   rstrb;
   logic                 rlast;
   logic                 empty, almost_empty;

   int n_run  = 0;
   int n_fail = 0;

   typedef struct {
      logic [M_WTH-1:0]   d;
      logic [M_WTH/8-1:0] s;
      logic               l;
   } word_t;

   typedef struct {
      logic [S_WTH-1:0]   d;
      logic [S_WTH/8-1:0] s;
      logic               l;
      logic               init;
      logic [LANE_W-1:0]  off;
      logic               commit;
   } beat_t;

   word_t fut_q[$];   // words of queued bursts not yet committed
   word_t exp_q[$];   // words expected to be held by the FIFO, head first
   beat_t beat_q[$];  // beats waiting to be driven

   axi_wdata_sfifo #(.S_WTH(S_WTH), .M_WTH(M_WTH), .DEPTH(DEPTH)) dut (
      .clk             (clk),
      .rstn            (rstn),
      .wen             (wen),
      .wdata           (wdata),
      .wstrb           (wstrb),
      .wlast           (wlast),
      .awaddr_offset   (awaddr_offset),
      .saddr_init_flag (saddr_init_flag),
      .full            (full),
      .almost_full     (almost_full),
      .ren             (ren),
      .rdata           (rdata),
      .rstrb           (rstrb),
      .rlast           (rlast),
      .empty           (empty),
      .almost_empty    (almost_empty)
   );

   always #5 clk = ~clk;

   // One directed cycle: drive at negedge, advance past the posedge to the next negedge
   task automatic drive(input logic w, input logic [31:0] d, input logic [3:0] s,
                        input logic l, input logic init, input logic off, input logic r);
      wen = w; wdata = d; wstrb = s; wlast = l;
      saddr_init_flag = init; awaddr_offset = off; ren = r;
      @(posedge clk);
      @(negedge clk);
      wen = 1'b0; ren = 1'b0; saddr_init_flag = 1'b0; wlast = 1'b0;
   endtask

   // Queue a burst with random data; expected words derived from beat slots
   task automatic add_burst(input int off, input int n);
      word_t wa[8];
      beat_t b;
      int    slot, nwords;
      nwords = (off + n + RATIO - 1) / RATIO;
      for (int k = 0; k < 8; k++) begin
         wa[k].d = '0; wa[k].s = '0; wa[k].l = 1'b0;
      end
      for (int i = 0; i < n; i++) begin
         slot     = off + i;
         b.d      = $urandom;
         b.s      = 4'($urandom);
         b.l      = (i == n - 1);
         b.init   = (i == 0);
         b.off    = (i == 0) ? LANE_W'(off) : LANE_W'($urandom);
         b.commit = ((slot % RATIO) == RATIO - 1) || (i == n - 1);
         wa[slot / RATIO].d[(slot % RATIO) * S_WTH +: S_WTH] = b.d;
         wa[slot / RATIO].s[(slot % RATIO) * 4 +: 4]         = b.s;
         beat_q.push_back(b);
      end
      wa[nwords - 1].l = 1'b1;
      for (int k = 0; k < nwords; k++) fut_q.push_back(wa[k]);
   endtask

   // One model-tracked cycle; a beat stays pending if the model says the FIFO is full
   task automatic cycle(input bit want_w, input bit want_r);
      beat_t b;
      word_t tmp;
      int    mc;
      bit    acc;
      mc  = exp_q.size();
      acc = 1'b0;
      wen = 1'b0; ren = want_r; saddr_init_flag = 1'b0; wlast = 1'b0;
      wdata = $urandom; wstrb = 4'($urandom); awaddr_offset = LANE_W'($urandom);
      if (want_w && beat_q.size() > 0) begin
         b = beat_q[0];
         wen = 1'b1; wdata = b.d; wstrb = b.s; wlast = b.l;
         saddr_init_flag = b.init; awaddr_offset = b.off;
         acc = (mc < DEPTH);
      end
      @(posedge clk);
      if (want_r && mc > 0) tmp = exp_q.pop_front();
      if (acc) begin
         b = beat_q.pop_front();
         if (b.commit) exp_q.push_back(fut_q.pop_front());
      end
      @(negedge clk);
      wen = 1'b0; ren = 1'b0;
   endtask

   task automatic test_reset();
      rstn = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
      awaddr_offset = '0; saddr_init_flag = 1'b0;
      repeat (3) @(negedge clk);
      n_run++;
      if ({full, almost_full, empty, almost_empty} !== 4'b0011) begin
         n_fail++; $display("FAIL reset_flags got %b want 0011", {full, almost_full, empty, almost_empty});
      end
      n_run++;
      if ({rdata, rstrb, rlast} !== '0) begin
         n_fail++; $display("FAIL reset_data got %h/%h/%b want 0", rdata, rstrb, rlast);
      end
      rstn = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_aligned();
      drive(1, 32'hA000_0000, 4'hF, 0, 1, 0, 0);
      drive(1, 32'hA000_0001, 4'hF, 0, 0, 1, 0);
      drive(1, 32'hA000_0002, 4'hF, 0, 0, 1, 0);
      drive(1, 32'hA000_0003, 4'hF, 1, 0, 0, 0);
      n_run++;
      if ({rdata, rstrb, rlast, empty, almost_empty} !== {64'hA000_0001_A000_0000, 8'hFF, 1'b0, 1'b0, 1'b0}) begin
         n_fail++; $display("FAIL aligned_w0 got %h/%h/%b e%b ae%b want a0000001a0000000/ff/0 e0 ae0",
                            rdata, rstrb, rlast, empty, almost_empty);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_run++;
      if ({rdata, rstrb, rlast, almost_empty} !== {64'hA000_0003_A000_0002, 8'hFF, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL aligned_w1 got %h/%h/%b ae%b want a0000003a0000002/ff/1 ae1",
                            rdata, rstrb, rlast, almost_empty);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_run++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL aligned_drain got empty=%b want 1", empty);
      end
   endtask

   task automatic test_unaligned();
      drive(1, 32'hB000_0000, 4'hF, 0, 1, 1, 0);
      drive(1, 32'hB000_0001, 4'hF, 0, 0, 0, 0);
      drive(1, 32'hB000_0002, 4'hF, 1, 0, 0, 0);
      n_run++;
      if ({rdata, rstrb, rlast} !== {64'hB000_0000_0000_0000, 8'hF0, 1'b0}) begin
         n_fail++; $display("FAIL unaligned_w0 got %h/%h/%b want b000000000000000/f0/0", rdata, rstrb, rlast);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_run++;
      if ({rdata, rstrb, rlast} !== {64'hB000_0002_B000_0001, 8'hFF, 1'b1}) begin
         n_fail++; $display("FAIL unaligned_w1 got %h/%h/%b want b0000002b0000001/ff/1", rdata, rstrb, rlast);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_single();
      drive(1, 32'hC000_00C0, 4'h3, 1, 1, 0, 0);
      n_run++;
      if ({rdata, rstrb, rlast, empty, almost_empty} !== {64'h0000_0000_C000_00C0, 8'h03, 1'b1, 1'b0, 1'b1}) begin
         n_fail++; $display("FAIL single got %h/%h/%b e%b ae%b want 00000000c00000c0/03/1 e0 ae1",
                            rdata, rstrb, rlast, empty, almost_empty);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
   endtask

   task automatic test_full();
      for (int i = 0; i < 4; i++) drive(1, 32'hD000_0000 + 32'(i), 4'hF, 1, 1, 0, 0);
      n_run++;
      if ({full, almost_full, empty} !== 3'b110) begin
         n_fail++; $display("FAIL full_flags got %b want 110", {full, almost_full, empty});
      end
      // Write while full must be dropped entirely (non-last beat would otherwise move the lane)
      drive(1, 32'hEEEE_EEEE, 4'hF, 0, 1, 0, 0);
      n_run++;
      if ({full, rdata} !== {1'b1, 64'h0000_0000_D000_0000}) begin
         n_fail++; $display("FAIL full_ignore got full=%b %h want 1 00000000d0000000", full, rdata);
      end
      // ren with wen while full: only the pop happens
      drive(1, 32'hEEEE_EEEE, 4'hF, 1, 1, 0, 1);
      n_run++;
      if ({full, almost_full, rdata} !== {1'b0, 1'b1, 64'h0000_0000_D000_0001}) begin
         n_fail++; $display("FAIL full_rw got f%b af%b %h want f0 af1 00000000d0000001", full, almost_full, rdata);
      end
      for (int i = 1; i < 4; i++) begin
         n_run++;
         if (rdata !== 64'(32'hD000_0000 + 32'(i))) begin
            n_fail++; $display("FAIL full_drain%0d got %h want %h", i, rdata, 64'(32'hD000_0000 + 32'(i)));
         end
         drive(0, 0, 0, 0, 0, 0, 1);
      end
      n_run++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL full_empty got empty=%b want 1", empty);
      end
   endtask

   // Random bursts with random ren/wen mix, every cycle checked against the model
   task automatic run_stream(input string tag, input int nb, input int wpct, input int rpct);
      word_t h;
      int    mc, cyc;
      for (int i = 0; i < nb; i++) add_burst(int'($urandom_range(0, 1)), int'($urandom_range(1, 6)));
      cyc = 0;
      while ((beat_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
         mc = exp_q.size();
         n_run++;
         if ({full, almost_full, empty, almost_empty} !==
             {mc == DEPTH, mc >= DEPTH - 1, mc == 0, mc <= 1}) begin
            n_fail++; $display("FAIL %s_flags cyc%0d got %b want %b", tag, cyc,
                               {full, almost_full, empty, almost_empty},
                               {mc == DEPTH, mc >= DEPTH - 1, mc == 0, mc <= 1});
         end
         if (mc > 0) h = exp_q[0];
         else begin h.d = '0; h.s = '0; h.l = 1'b0; end
         n_run++;
         if ({rdata, rstrb, rlast} !== {h.d, h.s, h.l}) begin
            n_fail++; $display("FAIL %s_head cyc%0d got %h/%h/%b want %h/%h/%b", tag, cyc,
                               rdata, rstrb, rlast, h.d, h.s, h.l);
         end
         cycle(int'($urandom_range(0, 99)) < wpct, int'($urandom_range(0, 99)) < rpct);
         cyc++;
      end
      n_run++;
      if (beat_q.size() != 0 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL %s_timeout got %0d beats/%0d words left want 0", tag, beat_q.size(), exp_q.size());
         beat_q.delete(); exp_q.delete(); fut_q.delete();
      end
   endtask

   task automatic test_stream();
      run_stream("stream", 20, 70, 55);
   endtask

   task automatic test_back_to_back();
      run_stream("b2b", 12, 100, 100);
      run_stream("burst_fill", 10, 100, 20);
   endtask

   task automatic test_reset_mid();
      // Partial word then reset; next beat without init must land in lane 0
      drive(1, 32'hF000_0000, 4'hF, 0, 1, 0, 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      drive(1, 32'h6000_0000, 4'hF, 0, 0, 1, 0);
      drive(1, 32'h6000_0001, 4'hF, 1, 0, 0, 0);
      n_run++;
      if ({rdata, rstrb, rlast, almost_empty} !== {64'h6000_0001_6000_0000, 8'hFF, 1'b1, 1'b1}) begin
         n_fail++; $display("FAIL rstmid_word got %h/%h/%b ae%b want 6000000160000000/ff/1 ae1",
                            rdata, rstrb, rlast, almost_empty);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      // Partial word then reset; an unaligned single beat must find lane 0 cleared
      drive(1, 32'hF000_0001, 4'hF, 0, 1, 0, 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      drive(1, 32'h7000_0000, 4'h5, 1, 1, 1, 0);
      n_run++;
      if ({rdata, rstrb, rlast} !== {64'h7000_0000_0000_0000, 8'h50, 1'b1}) begin
         n_fail++; $display("FAIL rstmid_pack got %h/%h/%b want 7000000000000000/50/1", rdata, rstrb, rlast);
      end
      drive(0, 0, 0, 0, 0, 0, 1);
      n_run++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_empty got empty=%b want 1", empty);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_aligned();
      test_unaligned();
      test_single();
      test_full();
      test_stream();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
